// File: rtl/lookup_scan_engine.sv
// -----------------------------------------------------------------------------
// lookup_scan_engine
//
// Sequential lookup over a DEPTH-entry table of array/element records. One
// query is accepted at a time (valid/ready). The table is then scanned one
// slot per clock. The result is presented on a valid/ready response port and
// held there until it is accepted.
//
// Slot k hits when all of the following are true:
//   - arr_def and elt_def are both set,
//   - array_code == handle and index == req_index,
//   - low <= metadata <= high,
//   - req_is_metadata is set.
// All comparisons are unsigned.
//
// Optional feature macro: LOOKUP_SCAN_BEST_RANK_EN
//   undefined : the scan stops at the first hitting slot (ascending order).
//   defined   : the scan visits every slot and reports the hit with the
//               largest rank. On equal rank the lower slot is kept.
//
// Parameters
//   DATA_W : width of every record / query field.
//   DEPTH  : number of table slots (>= 2).
//   SLOT_W : slot-number width.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset.
//   wr_en, wr_slot, wr_*  : table write port. Slots >= DEPTH are ignored.
//   clr                   : invalidate every slot. A same-cycle write wins.
//   req_valid/req_ready   : query handshake. req_ready == (state == IDLE).
//   req_handle/index/metadata/is_metadata : query fields.
//   resp_valid/resp_ready : result handshake.
//   resp_hit/value/context/slot : result; zeros on a miss.
//   busy                  : engine is not idle.
// -----------------------------------------------------------------------------
module lookup_scan_engine #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int SLOT_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic              wr_arr_def,
  input  logic              wr_elt_def,
  input  logic [DATA_W-1:0] wr_array_code,
  input  logic [DATA_W-1:0] wr_rank,
  input  logic [DATA_W-1:0] wr_low,
  input  logic [DATA_W-1:0] wr_high,
  input  logic [DATA_W-1:0] wr_index,
  input  logic [DATA_W-1:0] wr_value,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_handle,
  input  logic [DATA_W-1:0] req_index,
  input  logic [DATA_W-1:0] req_metadata,
  input  logic              req_is_metadata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_value,
  output logic [DATA_W-1:0] resp_context,
  output logic [SLOT_W-1:0] resp_slot,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Match predicate for one slot against the captured query.
  function automatic logic slot_hit(
    input logic              arr_def,
    input logic              elt_def,
    input logic [DATA_W-1:0] code,
    input logic [DATA_W-1:0] index,
    input logic [DATA_W-1:0] low,
    input logic [DATA_W-1:0] high,
    input logic [DATA_W-1:0] q_handle,
    input logic [DATA_W-1:0] q_index,
    input logic [DATA_W-1:0] q_meta,
    input logic              q_is_meta
  );
    logic code_ok;
    logic index_ok;
    logic range_ok;
    code_ok  = (code == q_handle);
    index_ok = (index == q_index);
    range_ok = (low <= q_meta) && (q_meta <= high);
    return arr_def & elt_def & code_ok & index_ok & range_ok & q_is_meta;
  endfunction

  // ---------------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------------
  logic              arr_def_r    [DEPTH];
  logic              elt_def_r    [DEPTH];
  logic [DATA_W-1:0] array_code_r [DEPTH];
  logic [DATA_W-1:0] rank_r       [DEPTH];
  logic [DATA_W-1:0] low_r        [DEPTH];
  logic [DATA_W-1:0] high_r       [DEPTH];
  logic [DATA_W-1:0] index_r      [DEPTH];
  logic [DATA_W-1:0] value_r      [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic sel_s;
    assign sel_s = wr_en && (wr_slot == SLOT_W'(k));

    // Per-slot record register. A write to this slot overrides a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        arr_def_r[k]    <= 1'b0;
        elt_def_r[k]    <= 1'b0;
        array_code_r[k] <= {DATA_W{1'b0}};
        rank_r[k]       <= {DATA_W{1'b0}};
        low_r[k]        <= {DATA_W{1'b0}};
        high_r[k]       <= {DATA_W{1'b0}};
        index_r[k]      <= {DATA_W{1'b0}};
        value_r[k]      <= {DATA_W{1'b0}};
      end else if (sel_s) begin
        arr_def_r[k]    <= wr_arr_def;
        elt_def_r[k]    <= wr_elt_def;
        array_code_r[k] <= wr_array_code;
        rank_r[k]       <= wr_rank;
        low_r[k]        <= wr_low;
        high_r[k]       <= wr_high;
        index_r[k]      <= wr_index;
        value_r[k]      <= wr_value;
      end else if (clr) begin
        arr_def_r[k]    <= 1'b0;
        elt_def_r[k]    <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control and query state
  // ---------------------------------------------------------------------------
  state_t            state_r,        state_s;
  logic [SLOT_W-1:0] ptr_r,          ptr_s;
  logic [DATA_W-1:0] q_handle_r,     q_handle_s;
  logic [DATA_W-1:0] q_index_r,      q_index_s;
  logic [DATA_W-1:0] q_meta_r,       q_meta_s;
  logic              q_is_meta_r,    q_is_meta_s;
  logic              resp_valid_r,   resp_valid_s;
  logic              resp_hit_r,     resp_hit_s;
  logic [DATA_W-1:0] resp_value_r,   resp_value_s;
  logic [DATA_W-1:0] resp_context_r, resp_context_s;
  logic [SLOT_W-1:0] resp_slot_r,    resp_slot_s;

`ifdef LOOKUP_SCAN_BEST_RANK_EN
  logic              best_hit_r,   best_hit_s;
  logic [DATA_W-1:0] best_rank_r,  best_rank_s;
  logic [DATA_W-1:0] best_value_r, best_value_s;
  logic [SLOT_W-1:0] best_slot_r,  best_slot_s;
  logic              take_s;
`endif

  // The slot under the pointer is read from the registered table, so a write
  // landing on it in the same cycle is not seen by this evaluation.
  logic              cur_hit_s;
  logic [DATA_W-1:0] cur_rank_s;
  logic [DATA_W-1:0] cur_value_s;
  logic              last_slot_s;

  // Evaluate the slot currently addressed by the scan pointer.
  always_comb begin
    cur_hit_s   = slot_hit(arr_def_r[ptr_r], elt_def_r[ptr_r],
                           array_code_r[ptr_r], index_r[ptr_r],
                           low_r[ptr_r], high_r[ptr_r],
                           q_handle_r, q_index_r, q_meta_r, q_is_meta_r);
    cur_rank_s  = rank_r[ptr_r];
    cur_value_s = value_r[ptr_r];
    last_slot_s = (ptr_r == SLOT_W'(DEPTH - 1));
  end

  // Next-state and next-output logic for the query FSM.
  always_comb begin
    state_s        = state_r;
    ptr_s          = ptr_r;
    q_handle_s     = q_handle_r;
    q_index_s      = q_index_r;
    q_meta_s       = q_meta_r;
    q_is_meta_s    = q_is_meta_r;
    resp_valid_s   = resp_valid_r;
    resp_hit_s     = resp_hit_r;
    resp_value_s   = resp_value_r;
    resp_context_s = resp_context_r;
    resp_slot_s    = resp_slot_r;
`ifdef LOOKUP_SCAN_BEST_RANK_EN
    best_hit_s     = best_hit_r;
    best_rank_s    = best_rank_r;
    best_value_s   = best_value_r;
    best_slot_s    = best_slot_r;
    // Replace only on a strictly greater rank so the lower slot wins a tie.
    take_s         = cur_hit_s && (!best_hit_r || (cur_rank_s > best_rank_r));
`endif

    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_s     = ST_SCAN;
          ptr_s       = {SLOT_W{1'b0}};
          q_handle_s  = req_handle;
          q_index_s   = req_index;
          q_meta_s    = req_metadata;
          q_is_meta_s = req_is_metadata;
`ifdef LOOKUP_SCAN_BEST_RANK_EN
          best_hit_s   = 1'b0;
          best_rank_s  = {DATA_W{1'b0}};
          best_value_s = {DATA_W{1'b0}};
          best_slot_s  = {SLOT_W{1'b0}};
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SCAN: begin
        ptr_s = ptr_r + SLOT_W'(1'b1);
`ifdef LOOKUP_SCAN_BEST_RANK_EN
        if (take_s) begin
          best_hit_s   = 1'b1;
          best_rank_s  = cur_rank_s;
          best_value_s = cur_value_s;
          best_slot_s  = ptr_r;
        end else begin
          best_hit_s   = best_hit_r;
        end
        // Best-so-far registers are zero when nothing hit, giving the miss encoding.
        if (last_slot_s) begin
          state_s        = ST_RESP;
          resp_valid_s   = 1'b1;
          resp_hit_s     = best_hit_s;
          resp_value_s   = best_value_s;
          resp_context_s = best_rank_s;
          resp_slot_s    = best_slot_s;
        end else begin
          state_s = ST_SCAN;
        end
`else
        if (cur_hit_s) begin
          state_s        = ST_RESP;
          resp_valid_s   = 1'b1;
          resp_hit_s     = 1'b1;
          resp_value_s   = cur_value_s;
          resp_context_s = cur_rank_s;
          resp_slot_s    = ptr_r;
        end else if (last_slot_s) begin
          state_s        = ST_RESP;
          resp_valid_s   = 1'b1;
          resp_hit_s     = 1'b0;
          resp_value_s   = {DATA_W{1'b0}};
          resp_context_s = {DATA_W{1'b0}};
          resp_slot_s    = {SLOT_W{1'b0}};
        end else begin
          state_s = ST_SCAN;
        end
`endif
      end

      ST_RESP: begin
        if (resp_ready) begin
          state_s        = ST_IDLE;
          resp_valid_s   = 1'b0;
          resp_hit_s     = 1'b0;
          resp_value_s   = {DATA_W{1'b0}};
          resp_context_s = {DATA_W{1'b0}};
          resp_slot_s    = {SLOT_W{1'b0}};
        end else begin
          state_s = ST_RESP;
        end
      end

      default: begin
        state_s        = ST_IDLE;
        resp_valid_s   = 1'b0;
        resp_hit_s     = 1'b0;
        resp_value_s   = {DATA_W{1'b0}};
        resp_context_s = {DATA_W{1'b0}};
        resp_slot_s    = {SLOT_W{1'b0}};
      end
    endcase
  end

  // FSM, query capture and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      ptr_r          <= {SLOT_W{1'b0}};
      q_handle_r     <= {DATA_W{1'b0}};
      q_index_r      <= {DATA_W{1'b0}};
      q_meta_r       <= {DATA_W{1'b0}};
      q_is_meta_r    <= 1'b0;
      resp_valid_r   <= 1'b0;
      resp_hit_r     <= 1'b0;
      resp_value_r   <= {DATA_W{1'b0}};
      resp_context_r <= {DATA_W{1'b0}};
      resp_slot_r    <= {SLOT_W{1'b0}};
    end else begin
      state_r        <= state_s;
      ptr_r          <= ptr_s;
      q_handle_r     <= q_handle_s;
      q_index_r      <= q_index_s;
      q_meta_r       <= q_meta_s;
      q_is_meta_r    <= q_is_meta_s;
      resp_valid_r   <= resp_valid_s;
      resp_hit_r     <= resp_hit_s;
      resp_value_r   <= resp_value_s;
      resp_context_r <= resp_context_s;
      resp_slot_r    <= resp_slot_s;
    end
  end

`ifdef LOOKUP_SCAN_BEST_RANK_EN
  // Best-so-far candidate held across the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_hit_r   <= 1'b0;
      best_rank_r  <= {DATA_W{1'b0}};
      best_value_r <= {DATA_W{1'b0}};
      best_slot_r  <= {SLOT_W{1'b0}};
    end else begin
      best_hit_r   <= best_hit_s;
      best_rank_r  <= best_rank_s;
      best_value_r <= best_value_s;
      best_slot_r  <= best_slot_s;
    end
  end
`endif

  assign req_ready    = (state_r == ST_IDLE);
  assign busy         = (state_r != ST_IDLE);
  assign resp_valid   = resp_valid_r;
  assign resp_hit     = resp_hit_r;
  assign resp_value   = resp_value_r;
  assign resp_context = resp_context_r;
  assign resp_slot    = resp_slot_r;

endmodule

// File: tb/tb_lookup_scan_engine.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for lookup_scan_engine (DATA_W=8, DEPTH=16).
// Latency is counted as the number of rising edges from the cycle in which
// req_valid is first driven up to the first sample with resp_valid high.
// -----------------------------------------------------------------------------
module tb_lookup_scan_engine;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int SLOT_W = 4;

`ifdef LOOKUP_SCAN_BEST_RANK_EN
  localparam bit BEST = 1'b1;
`else
  localparam bit BEST = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [SLOT_W-1:0] wr_slot;
  logic              wr_arr_def;
  logic              wr_elt_def;
  logic [DATA_W-1:0] wr_array_code;
  logic [DATA_W-1:0] wr_rank;
  logic [DATA_W-1:0] wr_low;
  logic [DATA_W-1:0] wr_high;
  logic [DATA_W-1:0] wr_index;
  logic [DATA_W-1:0] wr_value;
  logic              clr;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_handle;
  logic [DATA_W-1:0] req_index;
  logic [DATA_W-1:0] req_metadata;
  logic              req_is_metadata;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_hit;
  logic [DATA_W-1:0] resp_value;
  logic [DATA_W-1:0] resp_context;
  logic [SLOT_W-1:0] resp_slot;
  logic              busy;

  lookup_scan_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SLOT_W(SLOT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_en           (wr_en),
    .wr_slot         (wr_slot),
    .wr_arr_def      (wr_arr_def),
    .wr_elt_def      (wr_elt_def),
    .wr_array_code   (wr_array_code),
    .wr_rank         (wr_rank),
    .wr_low          (wr_low),
    .wr_high         (wr_high),
    .wr_index        (wr_index),
    .wr_value        (wr_value),
    .clr             (clr),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_handle      (req_handle),
    .req_index       (req_index),
    .req_metadata    (req_metadata),
    .req_is_metadata (req_is_metadata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_hit        (resp_hit),
    .resp_value      (resp_value),
    .resp_context    (resp_context),
    .resp_slot       (resp_slot),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int lat;
  logic              got_hit;
  logic [DATA_W-1:0] got_value;
  logic [DATA_W-1:0] got_ctx;
  logic [SLOT_W-1:0] got_slot;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a hitting-shape record (code 3, index 5, range 8..12) onto the write port.
  task automatic set_write(input int slot, input logic [7:0] rank, input logic [7:0] value);
    wr_en         = 1'b1;
    wr_slot       = SLOT_W'(slot);
    wr_arr_def    = 1'b1;
    wr_elt_def    = 1'b1;
    wr_array_code = 8'd3;
    wr_index      = 8'd5;
    wr_low        = 8'd8;
    wr_high       = 8'd12;
    wr_rank       = rank;
    wr_value      = value;
  endtask

  task automatic write_slot(input int slot, input logic [7:0] rank, input logic [7:0] value);
    set_write(slot, rank, value);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic clear_table();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic send_req(input logic [7:0] h, input logic [7:0] i,
                          input logic [7:0] m, input logic im);
    req_valid       = 1'b1;
    req_handle      = h;
    req_index       = i;
    req_metadata    = m;
    req_is_metadata = im;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
  endtask

  task automatic wait_resp();
    while (resp_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("resp_seen", {31'd0, resp_valid}, 32'd1);
    got_hit   = resp_hit;
    got_value = resp_value;
    got_ctx   = resp_context;
    got_slot  = resp_slot;
  endtask

  task automatic ack_resp(input string tag);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_eq({tag, "_ack_valid"}, {31'd0, resp_valid}, 32'd0);
    check_eq({tag, "_ack_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_query(input logic [7:0] m, input logic im);
    send_req(8'd3, 8'd5, m, im);
    wait_resp();
  endtask

  task automatic check_result(input string tag, input logic hit, input logic [7:0] value,
                              input logic [7:0] ctx, input logic [3:0] slot, input int exp_lat);
    check_eq({tag, "_hit"}, {31'd0, got_hit}, {31'd0, hit});
    check_eq({tag, "_value"}, {24'd0, got_value}, {24'd0, value});
    check_eq({tag, "_context"}, {24'd0, got_ctx}, {24'd0, ctx});
    check_eq({tag, "_slot"}, {28'd0, got_slot}, {28'd0, slot});
    if (exp_lat > 0) begin
      check_eq({tag, "_latency"}, lat, exp_lat);
    end
  endtask

  initial begin
    checks = 0; failures = 0; lat = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_slot = '0; wr_arr_def = 1'b0; wr_elt_def = 1'b0;
    wr_array_code = '0; wr_rank = '0; wr_low = '0; wr_high = '0; wr_index = '0;
    wr_value = '0; clr = 1'b0; req_valid = 1'b0; req_handle = '0; req_index = '0;
    req_metadata = '0; req_is_metadata = 1'b0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("rst_resp_hit", {31'd0, resp_hit}, 32'd0);
    check_eq("rst_resp_value", {24'd0, resp_value}, 32'd0);
    check_eq("rst_resp_context", {24'd0, resp_context}, 32'd0);
    check_eq("rst_resp_slot", {28'd0, resp_slot}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty table: miss after DEPTH+1 edges
    run_query(8'd10, 1'b1);
    check_result("empty", 1'b0, 8'h00, 8'h00, 4'd0, DEPTH + 1);
    ack_resp("empty");

    // Single record in slot 4
    write_slot(4, 8'd7, 8'hAA);
    run_query(8'd12, 1'b1);
    check_result("s4_hi_edge", 1'b1, 8'hAA, 8'd7, 4'd4, BEST ? DEPTH + 1 : 6);
    ack_resp("s4_hi_edge");
    run_query(8'd8, 1'b1);
    check_result("s4_lo_edge", 1'b1, 8'hAA, 8'd7, 4'd4, BEST ? DEPTH + 1 : 6);
    ack_resp("s4_lo_edge");
    run_query(8'd13, 1'b1);
    check_result("s4_above", 1'b0, 8'h00, 8'h00, 4'd0, DEPTH + 1);
    ack_resp("s4_above");
    run_query(8'd12, 1'b0);
    check_result("s4_nometa", 1'b0, 8'h00, 8'h00, 4'd0, DEPTH + 1);
    ack_resp("s4_nometa");

    // Response stall for 5 cycles with a write to slot 0 in the middle
    run_query(8'd10, 1'b1);
    check_result("stall_first", 1'b1, 8'hAA, 8'd7, 4'd4, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) set_write(0, 8'd0, 8'h55);
      @(posedge clk); #1;
      wr_en = 1'b0;
      check_eq("stall_valid", {31'd0, resp_valid}, 32'd1);
      check_eq("stall_value", {24'd0, resp_value}, 32'hAA);
      check_eq("stall_slot", {28'd0, resp_slot}, 32'd4);
      check_eq("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    ack_resp("stall");
    run_query(8'd10, 1'b1);
    if (BEST) check_result("after_stall", 1'b1, 8'hAA, 8'd7, 4'd4, DEPTH + 1);
    else      check_result("after_stall", 1'b1, 8'h55, 8'd0, 4'd0, 2);
    ack_resp("after_stall");

    // clr together with a write to slot 6: only slot 6 survives
    set_write(6, 8'd2, 8'h66);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; wr_en = 1'b0;
    run_query(8'd10, 1'b1);
    check_result("clr_wr", 1'b1, 8'h66, 8'd2, 4'd6, BEST ? DEPTH + 1 : 8);
    ack_resp("clr_wr");

    // Two hits: slot 2 rank 1, slot 9 rank 9
    clear_table();
    write_slot(2, 8'd1, 8'h22);
    write_slot(9, 8'd9, 8'h99);
    run_query(8'd10, 1'b1);
    if (BEST) check_result("two_hit", 1'b1, 8'h99, 8'd9, 4'd9, DEPTH + 1);
    else      check_result("two_hit", 1'b1, 8'h22, 8'd1, 4'd2, 4);
    ack_resp("two_hit");
    write_slot(2, 8'd5, 8'h22);
    write_slot(9, 8'd5, 8'h99);
    run_query(8'd10, 1'b1);
    check_result("tie", 1'b1, 8'h22, 8'd5, 4'd2, BEST ? DEPTH + 1 : 4);
    ack_resp("tie");

    // Write during SCAN with the pointer at 3: ahead (slot 10) is seen
    clear_table();
    send_req(8'd3, 8'd5, 8'd10, 1'b1);
    repeat (3) begin @(posedge clk); #1; lat++; end
    write_slot(10, 8'd4, 8'h10);
    lat++;
    wait_resp();
    check_result("scan_wr_ahead", 1'b1, 8'h10, 8'd4, 4'd10, BEST ? DEPTH + 1 : 12);
    ack_resp("scan_wr_ahead");

    // Behind the pointer (slot 1) is not seen
    clear_table();
    send_req(8'd3, 8'd5, 8'd10, 1'b1);
    repeat (3) begin @(posedge clk); #1; lat++; end
    write_slot(1, 8'd4, 8'h01);
    lat++;
    wait_resp();
    check_result("scan_wr_behind", 1'b0, 8'h00, 8'h00, 4'd0, DEPTH + 1);
    ack_resp("scan_wr_behind");

    // Reset mid-SCAN aborts with no response and empties the table
    clear_table();
    write_slot(15, 8'd3, 8'hF0);
    send_req(8'd3, 8'd5, 8'd10, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("abort_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      check_eq("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    run_query(8'd10, 1'b1);
    check_result("abort_empty", 1'b0, 8'h00, 8'h00, 4'd0, DEPTH + 1);
    ack_resp("abort_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lookup_scan_engine.md
# lookup_scan_engine

Sequential, parametrised successor to the single-entry ESFA lookup cell. It holds a DEPTH-entry table of array/element records and answers one lookup query at a time by scanning the table one slot per clock. A hit is an element whose index matches the query, whose array code matches the query handle, and whose [low, high] range contains the query metadata. The block sits between the ESFA command front-end (valid/ready request) and the result collector (valid/ready response).

## Interface
Parameters:
- DATA_W, 8: width of array_code, handle, rank, low, high, index, value, metadata.
- DEPTH, 16: number of table slots; must be ≥2.
- SLOT_W, $clog2(DEPTH): slot-number width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write one table slot this cycle.
- wr_slot  in  SLOT_W  slot to write; values ≥DEPTH are ignored.
- wr_arr_def, wr_elt_def  in  1 each  record valid flags.
- wr_array_code, wr_rank, wr_low, wr_high, wr_index, wr_value  in  DATA_W each  record fields.
- clr  in  1  invalidate every slot in one cycle.
- req_valid / req_ready  in / out  1  query handshake.
- req_handle, req_index, req_metadata  in  DATA_W  query fields.
- req_is_metadata  in  1  query carries metadata; if 0, no slot can hit.
- resp_valid / resp_ready  out / in  1  result handshake.
- resp_hit  out  1  a matching slot was found.
- resp_value, resp_context  out  DATA_W  value and rank of the winning slot; 0 on a miss.
- resp_slot  out  SLOT_W  winning slot; 0 on a miss.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Slot k hits when: arr_def & elt_def & (array_code == handle) & (index == req_index) & (low ≤ metadata ≤ high) & req_is_metadata. All comparisons are unsigned, DATA_W wide.
- State machine:
  - IDLE: req_ready = 1. On req_valid, capture the query, clear the scan pointer and best-so-far, go to SCAN.
  - SCAN: evaluate the slot at the pointer, then increment it. The end condition depends on the configured mode. On end, go to RESP.
  - RESP: resp_valid = 1 with stable outputs until resp_ready; then go to IDLE.
- Writes are accepted in every state. The slot under evaluation sees the pre-write contents. A write to a slot the scan has not yet reached is seen by the scan.
- clr and wr_en in the same cycle: all slots are cleared except wr_slot, which takes the write.
- Reset: every slot has arr_def = elt_def = 0 and fields 0. State is IDLE. req_ready = 1. resp_valid, resp_hit, resp_value, resp_context, resp_slot and busy are 0.
- Reset during SCAN or RESP aborts the query with no response.

## Timing
- A request is accepted at edge T, where req_valid & req_ready.
- Slot k is evaluated in the cycle after edge T+k.
- First-match mode: a hit at slot k gives resp_valid high after edge T+k+1. A miss gives resp_valid high after edge T+DEPTH.
- Best-rank mode: resp_valid is high after edge T+DEPTH regardless of outcome.
- resp_valid and the response data are held until resp_ready.
- The next request can be accepted one cycle after the response handshake. Throughput is one query per (latency + 1) cycles minimum.
- req_ready is combinationally equal to (state == IDLE).

## Configuration
- LOOKUP_SCAN_BEST_RANK_EN defined:
  - The scan always visits all DEPTH slots.
  - It reports the hit with the largest rank.
  - On equal rank, the lower slot wins (replacement only on strictly greater rank).
- LOOKUP_SCAN_BEST_RANK_EN undefined:
  - The scan stops at the first hitting slot in ascending order.
  - It reports that slot.

## Test plan
- After reset: all outputs 0 and req_ready = 1. Query handle=3, index=5, metadata=10 → miss after DEPTH+1 cycles, resp_hit = 0, value/context/slot = 0.
- Slot 4 = {code 3, index 5, low 8, high 12, rank 7, value 0xAA}. Query handle 3, index 5, metadata 12 → hit, value 0xAA, context 7, slot 4.
  - First-match mode: latency 6.
  - Metadata 13 → miss. req_is_metadata = 0 → miss.
- Slots 2 and 9 both hit, with ranks 1 and 9.
  - First-match mode → slot 2.
  - Best-rank mode → slot 9, context 9.
  - Equal ranks (both 5) → slot 2.
- resp_ready held low for 5 cycles → resp_valid and data remain stable and req_ready stays 0. A write to slot 0 during the stall is accepted.
- During SCAN with the pointer at 3, write a hitting record to slot 10 → it is found. Write to slot 1 → it is not found.
- Assert clr together with wr_en to slot 6 → only slot 6 is valid afterwards. Assert rst_n low mid-SCAN → no response, busy 0, table empty.
